decoder_scan_reg: RTL and testbench



---
 rtl/decoder_scan_reg.sv | 128 ++++++++++++
 tb/tb_decoder_scan_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_reg.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready input and optional auto-scan.
// Define DECODER_SCAN_EN to compile in the SCAN state, step divider and mode input.
module decoder_scan_reg #(
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    output logic                    in_ready,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        cur_idx
);

    localparam int OUT_N = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   mode_eff;

    function automatic logic [OUT_N-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [OUT_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef DECODER_SCAN_EN
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             div_tc;

    assign mode_eff = mode;
    assign div_tc   = (div_q == DIV_W'(SCAN_DIV - 1));

    // Divider only runs while staying in SCAN; any entry or other state restarts it at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (state_d == SCAN && state_q == SCAN && !div_tc) begin
            div_q <= div_q + DIV_W'(1);
        end else begin
            div_q <= '0;
        end
    end
`else
    logic unused_cfg;

    assign mode_eff   = 1'b0;
    assign unused_cfg = mode ^ (SCAN_DIV > 0);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode_eff ? SCAN : DIRECT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The handshake follows the registered state, never the raw mode pin.
    assign in_ready = (state_q == DIRECT);

    // Outputs react to the state being entered on this edge, so a transition and its
    // effect on y land on the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            out_valid <= 1'b0;
            cur_idx   <= '0;
        end else begin
            case (state_d)
                IDLE: begin
                    y         <= '0;
                    out_valid <= 1'b0;
                end
                DIRECT: begin
                    if (in_ready && in_valid) begin
                        y         <= one_hot(sel);
                        cur_idx   <= sel;
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
`ifdef DECODER_SCAN_EN
                SCAN: begin
                    if (state_q != SCAN) begin
                        y         <= one_hot('0);
                        cur_idx   <= '0;
                        out_valid <= 1'b1;
                    end else if (div_tc) begin
                        // Index width is exactly log2(OUT_N), so the add wraps OUT_N-1 -> 0.
                        y         <= one_hot(cur_idx + SEL_W'(1));
                        cur_idx   <= cur_idx + SEL_W'(1);
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
`endif
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_reg.sv
// Directed self-checking bench for decoder_scan_reg (SEL_W=2, SCAN_DIV=4).
// Scan scenarios run when DECODER_SCAN_EN is defined; the direct-only scenario otherwise.
module tb_decoder_scan_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [1:0] sel;
    logic       in_ready;
    logic [3:0] y;
    logic       out_valid;
    logic [1:0] cur_idx;

    int n_checks = 0;
    int n_pass   = 0;

    decoder_scan_reg #(.SEL_W(2), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .sel       (sel),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .cur_idx   (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ey, input logic eov,
                             input logic [1:0] eidx);
        check({tag, ".y"}, 32'(y), 32'(ey));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        check({tag, ".cur_idx"}, 32'(cur_idx), 32'(eidx));
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        sel      = 2'd0;
        #12;
        check_out("reset", 4'b0000, 1'b0, 2'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);

        // Release between edges; first edge enters DIRECT with nothing transferred.
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        check("enter_direct.in_ready", 32'(in_ready), 32'd1);
        check_out("enter_direct", 4'b0000, 1'b0, 2'd0);

        // Back-to-back transfers sel=0..3.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            check_out($sformatf("direct%0d", i), 4'(1 << i), 1'b1, 2'(i));
        end

        in_valid = 1'b0;
        tick();
        check_out("direct_hold", 4'b1000, 1'b0, 2'd3);

        // Same sel twice in a row still pulses out_valid each time.
        in_valid = 1'b1;
        sel      = 2'd2;
        tick();
        check_out("same_sel_a", 4'b0100, 1'b1, 2'd2);
        tick();
        check_out("same_sel_b", 4'b0100, 1'b1, 2'd2);

`ifdef DECODER_SCAN_EN
        // mode=1 while offering sel=2: handshake closes, scan starts at line 0.
        mode = 1'b1;
        tick();
        check("scan_entry.in_ready", 32'(in_ready), 32'd0);
        check_out("scan_entry", 4'b0001, 1'b1, 2'd0);

        // 16 further cycles: a step every 4th edge, wrapping 3 -> 0.
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_out($sformatf("scan_k%0d", k), 4'(1 << ((k / 4) % 4)),
                      1'((k % 4) == 0), 2'((k / 4) % 4));
        end
        for (int k = 17; k <= 24; k++) tick();
        check_out("scan_k24", 4'b0100, 1'b1, 2'd2);

        // Disable mid-scan: y clears, cur_idx holds.
        en = 1'b0;
        tick();
        check_out("disable", 4'b0000, 1'b0, 2'd2);
        check("disable.in_ready", 32'(in_ready), 32'd0);

        en = 1'b1;
        tick();
        check_out("reenable_scan", 4'b0001, 1'b1, 2'd0);

        // Back to direct: ready rises after one edge, sel=2 lands the edge after.
        mode = 1'b0;
        tick();
        check("to_direct.in_ready", 32'(in_ready), 32'd1);
        check_out("to_direct", 4'b0001, 1'b0, 2'd0);
        tick();
        check_out("to_direct_xfer", 4'b0100, 1'b1, 2'd2);

        // Async reset between edges mid-scan.
        in_valid = 1'b0;
        mode     = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        check_out("pre_reset_scan", 4'b0010, 1'b0, 2'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 4'b0000, 1'b0, 2'd0);
        check("async_reset.in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check_out("post_reset_scan", 4'b0001, 1'b1, 2'd0);
`else
        // Direct-only build: mode is ignored, sel=3 decodes and nothing scans.
        mode = 1'b1;
        sel  = 2'd3;
        tick();
        check("noscan.in_ready", 32'(in_ready), 32'd1);
        check_out("noscan_xfer", 4'b1000, 1'b1, 2'd3);
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_out($sformatf("noscan_hold%0d", k), 4'b1000, 1'b0, 2'd3);
        end

        en = 1'b0;
        tick();
        check_out("noscan_disable", 4'b0000, 1'b0, 2'd3);
        check("noscan_disable.in_ready", 32'(in_ready), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
